modexp_arbiter: RTL and testbench

Round-robin scheduler that shares a single modular-exponentiation engine (result = a^b mod m) among N_REQ requesters. Each requester submits operands over a valid/ready handshake. The arbiter latches the operands, pulses the engine start, waits for engine done, then returns the result to the owning requester over a per-requester valid/ready response channel. It sits between the crypto clients and the engine instance and is the only block that drives the engine's inputs.

---
 rtl/modexp_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/modexp_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_modexp_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// ---------------------------------------------------------------------------
// modexp_pkg
//   Shared definitions for the modular-exponentiation arbiter slice.
//   - state_e     : arbiter FSM states
//   - WIDTH_DEF   : default operand / result width
//   - N_REQ_DEF   : default number of requesters
//   - N_REQ_MAX   : largest supported number of requesters
//   - idx_width() : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package modexp_pkg;

  localparam int WIDTH_DEF = 256;
  localparam int N_REQ_DEF = 4;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    ARM     = 3'd2,
    WAIT    = 3'd3,
    RESPOND = 3'd4
  } state_e;

  // At least one bit, even though a single requester is not a supported setup.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first asserted request found
//   when searching upward from ptr, wrapping past N_REQ-1 back to 0.
//
//   Ports
//     req       in   N_REQ   request vector
//     ptr       in   IDX_W   highest-priority requester index
//     gnt       out  N_REQ   one-hot grant (all zero when no request)
//     gnt_idx   out  IDX_W   index of the granted requester
//     gnt_valid out  1       some request is granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import modexp_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Position k places above ptr, wrapped into 0..N_REQ-1.
  function automatic int wrap_idx(int p, int k);
    int s;
    s = p + k;
    return (s >= N_REQ) ? (s - N_REQ) : s;
  endfunction

  always_comb begin
    // NOTE: every output is given a default before the search loop, so no
    // path through this block leaves a value unassigned and no latch is
    // inferred.
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    gnt       = '0;
    // Walk from the lowest-priority position down to ptr itself; the last
    // hit written is therefore the highest-priority one.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IDX_W'(wrap_idx(int'(ptr), k))]) begin
        gnt_idx   = IDX_W'(wrap_idx(int'(ptr), k));
        gnt_valid = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      gnt[j] = gnt_valid && (gnt_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// ---------------------------------------------------------------------------
// modexp_arbiter
//   Shares one modular-exponentiation engine (a^b mod m) among N_REQ
//   requesters. A request is taken by round robin, its operands are latched
//   and presented to the engine, the engine result is captured and handed
//   back to the owning requester over its response channel.
//
//   Parameters
//     N_REQ  number of requesters (2..8)
//     WIDTH  operand / result width
//
//   Ports
//     clk         in   1            rising-edge clock
//     reset       in   1            synchronous, active-high
//     req_valid   in   N_REQ        per-requester request valid
//     req_ready   out  N_REQ        per-requester accept, at most one high
//     req_a/b/m   in   N_REQ*WIDTH  base / exponent / modulus, slice i = req i
//     rsp_valid   out  N_REQ        one-hot response valid
//     rsp_ready   in   N_REQ        per-requester response accept
//     rsp_result  out  WIDTH        shared response data
//     eng_start   out  1            one-cycle engine start pulse
//     eng_a/b/m   out  WIDTH        engine operands, stable while it runs
//     eng_result  in   WIDTH        engine result
//     eng_done    in   1            engine done (level, held until next start)
//
//   Build option
//     MODEXP_ARB_BYPASS_EN : when defined, m == 1 (result 0) and b == 0 with
//     m != 0 (result 1) are answered directly from IDLE without the engine.
// ---------------------------------------------------------------------------
module modexp_arbiter
  import modexp_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_m,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   eng_start,
  output logic [WIDTH-1:0]       eng_a,
  output logic [WIDTH-1:0]       eng_b,
  output logic [WIDTH-1:0]       eng_m,
  input  logic [WIDTH-1:0]       eng_result,
  input  logic                   eng_done
);

  localparam int IDX_W = idx_width(N_REQ);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [WIDTH-1:0]  a_q, b_q, m_q;
  logic [WIDTH-1:0]  result_q;
  logic              eng_start_q;
  logic [N_REQ-1:0]  rsp_valid_q;

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic              req_fire;
  logic              rsp_fire;
  logic [WIDTH-1:0]  sel_a, sel_b, sel_m;
  logic [N_REQ-1:0]  owner_oh;
  logic [IDX_W-1:0]  ptr_next;
  logic              byp_hit;
  logic [WIDTH-1:0]  byp_val;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // The accept is combinational so a request can be taken in the same
  // cycle it is presented. It is gated with reset so that no requester sees
  // an accept while the block is being cleared.
  assign req_ready = (state_q == IDLE && !reset && gnt_valid) ? gnt : '0;
  assign req_fire  = |(req_valid & req_ready);

  // rsp_valid_q only ever holds the owner's bit, so the other requesters'
  // rsp_ready bits are masked out here.
  assign rsp_fire  = |(rsp_valid_q & rsp_ready);

  // Operand slice of the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_m = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt[j]) begin
        sel_a = req_a[j*WIDTH +: WIDTH];
        sel_b = req_b[j*WIDTH +: WIDTH];
        sel_m = req_m[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int j = 0; j < N_REQ; j++) begin
      owner_oh[j] = (owner_q == IDX_W'(j));
    end
  end

  assign ptr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef MODEXP_ARB_BYPASS_EN
  // m == 1 takes precedence: x mod 1 is 0 whatever the exponent. m == 0 is
  // left to the engine so its own convention for that case applies.
  logic byp_mod_one;
  logic byp_exp_zero;
  assign byp_mod_one  = (sel_m == WIDTH'(1));
  assign byp_exp_zero = (sel_b == '0) && (sel_m != '0);
  assign byp_hit      = byp_mod_one || byp_exp_zero;
  assign byp_val      = byp_mod_one ? '0 : WIDTH'(1);
`else
  assign byp_hit      = 1'b0;
  assign byp_val      = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all state is written with non-blocking assignments, so every
    // register in this block updates from the values present before the
    // edge, independent of statement order.
    if (reset) begin
      // Operand and result registers are cleared too: eng_a/b/m and
      // rsp_result are visible outputs and must read zero out of reset.
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      result_q    <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            owner_q <= gnt_idx;
            a_q     <= sel_a;
            b_q     <= sel_b;
            m_q     <= sel_m;
            if (byp_hit) begin
              result_q    <= byp_val;
              rsp_valid_q <= gnt;
              state_q     <= RESPOND;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= LAUNCH;
            end
          end
        end

        LAUNCH: begin
          eng_start_q <= 1'b0;
          state_q     <= ARM;
        end

        // The engine may still show done from the previous job on the
        // cycle after it sampled start; this cycle deliberately ignores it.
        ARM: begin
          state_q <= WAIT;
        end

        WAIT: begin
          if (eng_done) begin
            result_q    <= eng_result;
            rsp_valid_q <= owner_oh;
            state_q     <= RESPOND;
          end
        end

        RESPOND: begin
          if (rsp_fire) begin
            rsp_valid_q <= '0;
            ptr_q       <= ptr_next;
            state_q     <= IDLE;
          end
        end

        default: begin
          eng_start_q <= 1'b0;
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_a      = a_q;
  assign eng_b      = b_q;
  assign eng_m      = m_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_modexp_arbiter
//   Self-checking bench for modexp_arbiter (N_REQ = 4, WIDTH = 256).
//   A behavioural engine answers start pulses after a programmable latency.
//   A transaction-level model tracks whether a job is outstanding, which
//   requester owns it, when the handshake happened and when the engine
//   reported done, and from that predicts every output each cycle.
//   Expected results are plain modular exponentiation of the submitted
//   operands. Honours MODEXP_ARB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_modexp_arbiter;
  import modexp_pkg::*;

  localparam int N = 4;
  localparam int W = 256;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b, req_m;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           eng_start;
  logic [W-1:0]   eng_a, eng_b, eng_m;
  logic [W-1:0]   eng_result = '0;
  logic           eng_done = 1'b0;

  always #5 clk = ~clk;

  modexp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_m      (req_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_m      (eng_m),
    .eng_result (eng_result),
    .eng_done   (eng_done)
  );

  // ---------------- arithmetic reference ----------------
  function automatic logic [W-1:0] modexp(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [W-1:0] m);
    logic [2*W-1:0] r, x, mm;
    if (m == '0) return '0;
    mm = {{W{1'b0}}, m};
    r  = (2*W)'(1) % mm;
    x  = {{W{1'b0}}, a} % mm;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[W-1:0];
  endfunction

  // ---------------- behavioural engine ----------------
  int           eng_lat = 3;
  int           eng_cnt;
  bit           eng_busy;
  logic [W-1:0] eng_val;

  always @(posedge clk) begin
    if (reset) begin
      eng_done   <= 1'b0;
      eng_result <= '0;
      eng_busy    = 1'b0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      eng_val   = modexp(eng_a, eng_b, eng_m);
      eng_cnt   = eng_lat;
      eng_busy  = 1'b1;
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_done   <= 1'b1;
        eng_result <= eng_val;
        eng_busy    = 1'b0;
      end else begin
        eng_cnt--;
      end
    end
  end

  // ---------------- stimulus state ----------------
  logic [N-1:0] pend = '0;
  logic [W-1:0] pa[N], pb[N], pm[N];
  logic [N-1:0] rsp_hold = '0;
  bit           rsp_rand = 1'b0;
  bit           rst_req  = 1'b1;

  // ---------------- transaction model ----------------
  int           cyc = 0;
  bit           busy_m = 1'b0;
  bit           byp_m = 1'b0;
  int           own_m = 0;
  int           ptr_m = 0;
  int           t_hs = 0;
  int           rsp_from = -1;
  logic [W-1:0] exp_res, exp_a, exp_b, exp_m;
  bit           rst_seen = 1'b0;
  bit           armed = 1'b0;
  int           grants[$];
  logic [W-1:0] last_res[N];
  int           n_resp[N];
  int           n_starts = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] p, int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit is_bypass(logic [W-1:0] b, logic [W-1:0] m);
`ifdef MODEXP_ARB_BYPASS_EN
    return (m == W'(1)) || (b == '0 && m != '0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive at the falling edge, check after settling,
  // then advance the model by what the next rising edge will do.
  task automatic step();
    logic [N-1:0] exp_rdy, exp_rspv;
    bit           exp_start;
    int           g;
    @(negedge clk);
    cyc++;
    reset     = rst_req;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
      req_m[i*W +: W] = pm[i];
      rsp_ready[i]    = ~rsp_hold[i] & (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    #1;
    g         = (!busy_m && !reset) ? pick(pend, ptr_m) : -1;
    exp_rdy   = onehot(g);
    exp_start = busy_m && !byp_m && (cyc == t_hs + 1);
    exp_rspv  = (busy_m && rsp_from >= 0 && cyc >= rsp_from) ? onehot(own_m) : '0;
    if (armed) begin
      check("req_ready", W'(req_ready), W'(exp_rdy));
      check("one_ready", W'($countones(req_ready) <= 1), W'(1));
      check("eng_start", W'(eng_start), W'(exp_start));
      check("rsp_valid", W'(rsp_valid), W'(exp_rspv));
      if (exp_rspv != '0) check("rsp_result", rsp_result, exp_res);
      if (busy_m && !byp_m && rsp_from < 0 && cyc >= t_hs + 1) begin
        check("eng_a", eng_a, exp_a);
        check("eng_b", eng_b, exp_b);
        check("eng_m", eng_m, exp_m);
      end
      if (rst_seen) begin
        check("rst_rsp_result", rsp_result, '0);
        check("rst_eng_a", eng_a, '0);
        check("rst_eng_b", eng_b, '0);
        check("rst_eng_m", eng_m, '0);
      end
    end
    if (eng_start) n_starts++;

    if (reset) begin
      busy_m   = 1'b0;
      ptr_m    = 0;
      rsp_from = -1;
      rst_seen = 1'b1;
      armed    = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (busy_m && !byp_m && rsp_from < 0 && cyc >= t_hs + 3 && eng_done) begin
        rsp_from = cyc + 1;
      end else if (exp_rspv != '0 && rsp_ready[own_m]) begin
        last_res[own_m] = rsp_result;
        n_resp[own_m]++;
        busy_m   = 1'b0;
        ptr_m    = (own_m + 1) % N;
        rsp_from = -1;
      end else if (g >= 0) begin
        busy_m   = 1'b1;
        own_m    = g;
        t_hs     = cyc;
        exp_a    = pa[g];
        exp_b    = pb[g];
        exp_m    = pm[g];
        exp_res  = modexp(pa[g], pb[g], pm[g]);
        byp_m    = is_bypass(pb[g], pm[g]);
        rsp_from = byp_m ? cyc + 1 : -1;
        pend[g]  = 1'b0;
        grants.push_back(g);
      end
    end
  endtask

  task automatic submit(int i, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m);
    pa[i]   = a;
    pb[i]   = b;
    pm[i]   = m;
    pend[i] = 1'b1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((busy_m || pend != '0) && n < budget) begin
      step();
      n++;
    end
    if (busy_m || pend != '0) check("drain_timeout", W'(0), W'(1));
  endtask

  task automatic do_reset();
    pend    = '0;
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0;
    step();
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, base, nr;
    logic [W-1:0] big_a, big_b, big_m, big_r;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0; pb[i] = '0; pm[i] = '0;
      last_res[i] = '0; n_resp[i] = 0;
    end
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_m = '0;

    // Reset state
    do_reset();

    // Single request
    s0 = n_starts; nr = n_resp[0];
    submit(0, W'(7), W'(5), W'(13));
    drain(200);
    check("single_starts", W'(n_starts - s0), W'(1));
    check("single_count", W'(n_resp[0]), W'(nr + 1));
    check("single_result", last_res[0], W'(11));

    // All requesters at once, straight after reset
    do_reset();
    base = grants.size();
    eng_lat = 5;
    for (int i = 0; i < N; i++) submit(i, W'(9081235), W'(3728103), W'(98234125));
    drain(400);
    check("all_grant_count", W'(grants.size() - base), W'(N));
    if (grants.size() - base == N)
      for (int k = 0; k < N; k++) check("all_grant_order", W'(grants[base + k]), W'(k));
    for (int i = 0; i < N; i++) check("all_result", last_res[i], W'(23831250));

    // Backpressure on requester 1 with requester 2 waiting
    base = grants.size();
    rsp_hold[1] = 1'b1;
    eng_lat = 2;
    submit(1, W'(7), W'(5), W'(13));
    begin
      int n = 0;
      while (rsp_valid[1] !== 1'b1 && n < 100) begin step(); n++; end
      check("bp_rsp_seen", W'(rsp_valid[1]), W'(1));
    end
    submit(2, W'(1), W'(2), W'(5));
    repeat (10) step();
    check("bp_not_granted", W'(pend[2]), W'(1));
    rsp_hold[1] = 1'b0;
    drain(200);
    check("bp_grant_count", W'(grants.size() - base), W'(2));
    if (grants.size() - base == 2) begin
      check("bp_first", W'(grants[base]), W'(1));
      check("bp_second", W'(grants[base + 1]), W'(2));
    end
    check("bp_res1", last_res[1], W'(11));
    check("bp_res2", last_res[2], W'(1));

    // Full-width operands
    big_a = 256'hbab4ced90e27661d82339709844497ee86760526d9766009083c2f39a55c6049;
    big_b = 256'h715637a09f055934ea3566b2c942a2db040ef70a64aab4d086e50291cef6e547;
    big_m = 256'hc485187e36c221d024345106cf3224212172df81d5be65306bedc648f00a3553;
    big_r = 256'h9c0d4b2181f8e1b369a00fb4a9f18d1799f3022625e1f63bf7d404ccd2e53237;
    submit(3, big_a, big_b, big_m);
    drain(200);
    check("wide_result", last_res[3], big_r);

    // Trivial operands
    s0 = n_starts;
`ifdef MODEXP_ARB_BYPASS_EN
    submit(0, W'(3), W'(4), W'(1));
    drain(50);
    check("byp_m1", last_res[0], W'(0));
    submit(1, W'(9), W'(0), W'(5));
    drain(50);
    check("byp_b0", last_res[1], W'(1));
    check("byp_starts", W'(n_starts - s0), W'(0));
`else
    submit(0, W'(1), W'(2), W'(5));
    drain(50);
    check("nobyp_result", last_res[0], W'(1));
    check("nobyp_starts", W'(n_starts - s0), W'(1));
`endif

    // Reset while the engine is running
    eng_lat = 20;
    nr = n_resp[2];
    submit(2, W'(7), W'(5), W'(13));
    begin
      int n = 0;
      while (!(busy_m && cyc >= t_hs + 4) && n < 50) begin step(); n++; end
      check("mid_in_wait", W'(busy_m && cyc >= t_hs + 4), W'(1));
    end
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (30) step();
    check("mid_lost_job", W'(n_resp[2]), W'(nr));
    eng_lat = 3;
    submit(2, W'(7), W'(5), W'(13));
    drain(100);
    check("mid_after_count", W'(n_resp[2]), W'(nr + 1));
    check("mid_after_result", last_res[2], W'(11));

    // Randomized traffic with random response backpressure
    rsp_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      eng_lat = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0: submit(i, rand_w(), rand_w(), rand_w() | W'(1));
            1: submit(i, W'($urandom_range(0, 1000)), W'($urandom_range(0, 50)),
                      W'($urandom_range(1, 1000)));
            2: submit(i, rand_w(), W'(0), W'($urandom_range(1, 100)));
            default: submit(i, rand_w(), rand_w(), W'(1));
          endcase
        end else if (pend[i] && $urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step();
    end
    drain(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
